// File: rtl/spike_encoder.sv
// rtl/spike_encoder.sv - rate-coded spike train generator feeding the LIF node block
// Four phase-accumulator channels step once per adv strobe for a WINDOW-step frame.
module spike_encoder #(
    parameter int WINDOW = 16,
    parameter int SW     = $clog2(WINDOW)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [1:0]    cfg_ch,
    input  logic [3:0]    cfg_rate,
    input  logic [3:0]    cfg_weight,
    input  logic          start,
    input  logic          adv,
    output logic [3:0]    out1,
    output logic [3:0]    out2,
    output logic [3:0]    out3,
    output logic [3:0]    out4,
    output logic          busy,
    output logic          frame_done,
    output logic [SW-1:0] step_idx
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_q;
    state_t state_nxt;

    logic [3:0]    rate_q   [4];
    logic [3:0]    weight_q [4];
    logic [3:0]    acc_q    [4];
    logic [3:0]    out_q    [4];
    logic [4:0]    sum      [4];
    logic [SW-1:0] step_q;
    logic          last_step;

    assign last_step = (step_q == SW'(WINDOW - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            S_IDLE:  if (start) state_nxt = S_RUN;
            S_RUN:   if (adv && last_step) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        cfg_ready  = (state_q == S_IDLE);
        busy       = (state_q == S_RUN);
        frame_done = (state_q == S_DONE);
    end

    // The carry out of the 4-bit phase add is the fire decision for this step.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            sum[i] = {1'b0, acc_q[i]} + {1'b0, rate_q[i]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                rate_q[i]   <= 4'd0;
                weight_q[i] <= 4'd0;
                acc_q[i]    <= 4'd0;
                out_q[i]    <= 4'd0;
            end
            step_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cfg_valid) begin
                        rate_q[cfg_ch]   <= cfg_rate;
                        weight_q[cfg_ch] <= cfg_weight;
                    end
                    if (start) begin
                        for (int i = 0; i < 4; i++) begin
                            acc_q[i] <= 4'd0;
                        end
                        step_q <= '0;
                    end
                end
                S_RUN: begin
                    if (adv) begin
                        for (int i = 0; i < 4; i++) begin
                            acc_q[i] <= sum[i][3:0];
                            out_q[i] <= sum[i][4] ? weight_q[i] : 4'd0;
                        end
                        step_q <= last_step ? '0 : step_q + SW'(1);
                    end
                end
                S_DONE: begin
                    // Last step stays visible through DONE and is cleared on the way out.
                    for (int i = 0; i < 4; i++) begin
                        out_q[i] <= 4'd0;
                    end
                    step_q <= '0;
                end
                default: begin
                    step_q <= '0;
                end
            endcase
        end
    end

    assign out1     = out_q[0];
    assign out2     = out_q[1];
    assign out3     = out_q[2];
    assign out4     = out_q[3];
    assign step_idx = step_q;

endmodule

// File: tb/tb_spike_encoder.sv
// tb/tb_spike_encoder.sv - randomized self-checking bench for spike_encoder
module tb_spike_encoder;

    localparam int WINDOW = 16;
    localparam int SW     = $clog2(WINDOW);

    logic          clk;
    logic          rst_n;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [1:0]    cfg_ch;
    logic [3:0]    cfg_rate;
    logic [3:0]    cfg_weight;
    logic          start;
    logic          adv;
    logic [3:0]    out1, out2, out3, out4;
    logic          busy;
    logic          frame_done;
    logic [SW-1:0] step_idx;

    spike_encoder #(.WINDOW(WINDOW), .SW(SW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_ch     (cfg_ch),
        .cfg_rate   (cfg_rate),
        .cfg_weight (cfg_weight),
        .start      (start),
        .adv        (adv),
        .out1       (out1),
        .out2       (out2),
        .out3       (out3),
        .out4       (out4),
        .busy       (busy),
        .frame_done (frame_done),
        .step_idx   (step_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Reference: mode 0 idle / 1 run / 2 done; firing from the closed form
    // floor((k+1)*rate/16) > floor(k*rate/16) for step k.
    int m_mode = 0;
    int m_step = 0;
    int m_rate [4] = '{0, 0, 0, 0};
    int m_wt   [4] = '{0, 0, 0, 0};
    int m_out  [4] = '{0, 0, 0, 0};

    always @(posedge clk) begin
        if (!rst_n) begin
            m_mode = 0;
            m_step = 0;
            for (int c = 0; c < 4; c++) begin
                m_rate[c] = 0; m_wt[c] = 0; m_out[c] = 0;
            end
        end else begin
            case (m_mode)
                0: begin
                    if (cfg_valid) begin
                        m_rate[cfg_ch] = int'(cfg_rate);
                        m_wt[cfg_ch]   = int'(cfg_weight);
                    end
                    if (start) begin
                        m_mode = 1;
                        m_step = 0;
                    end
                end
                1: begin
                    if (adv) begin
                        for (int c = 0; c < 4; c++) begin
                            if (((m_step + 1) * m_rate[c]) / 16 > (m_step * m_rate[c]) / 16)
                                m_out[c] = m_wt[c];
                            else
                                m_out[c] = 0;
                        end
                        if (m_step == WINDOW - 1) begin
                            m_mode = 2;
                            m_step = 0;
                        end else begin
                            m_step++;
                        end
                    end
                end
                default: begin
                    for (int c = 0; c < 4; c++) m_out[c] = 0;
                    m_mode = 0;
                end
            endcase
        end
    end

    bit chk_en   = 0;
    int busy_cnt = 0;
    int done_cnt = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("out1", int'(out1), m_out[0]);
            chk("out2", int'(out2), m_out[1]);
            chk("out3", int'(out3), m_out[2]);
            chk("out4", int'(out4), m_out[3]);
            chk("busy", int'(busy), int'(m_mode == 1));
            chk("frame_done", int'(frame_done), int'(m_mode == 2));
            chk("cfg_ready", int'(cfg_ready), int'(m_mode == 0));
            if (m_mode != 2) chk("step_idx", int'(step_idx), m_step);
            busy_cnt += int'(busy);
            done_cnt += int'(frame_done);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input int ch, input int r, input int w);
        cfg_valid  = 1'b1;
        cfg_ch     = 2'(ch);
        cfg_rate   = 4'(r);
        cfg_weight = 4'(w);
        cyc();
        cfg_valid  = 1'b0;
    endtask

    int              fcnt  [4];
    logic [WINDOW-1:0] fmask [4];

    // mode 0: adv held high, 1: adv pattern 1,0,0,1, 2: random adv
    task automatic run_frame(input int mode, input bit mid_start, input bit run_cfg);
        int k;
        int c;
        bit a;
        int ov [4];
        for (int i = 0; i < 4; i++) begin
            fcnt[i]  = 0;
            fmask[i] = '0;
        end
        busy_cnt = 0;
        done_cnt = 0;
        start = 1'b1;
        cyc();
        start     = 1'b0;
        cfg_valid = 1'b0;
        k = 0;
        c = 0;
        while (k < WINDOW && c < 400) begin
            case (mode)
                0:       a = 1'b1;
                1:       a = (c % 4 == 0) || (c % 4 == 3);
                default: a = ($urandom_range(0, 3) != 0);
            endcase
            adv   = a;
            start = mid_start && (k == 5);
            if (run_cfg && k == 3) begin
                cfg_valid  = 1'b1;
                cfg_ch     = 2'd3;
                cfg_rate   = 4'd15;
                cfg_weight = 4'd15;
            end
            cyc();
            adv       = 1'b0;
            start     = 1'b0;
            cfg_valid = 1'b0;
            if (a) begin
                ov = '{int'(out1), int'(out2), int'(out3), int'(out4)};
                for (int i = 0; i < 4; i++) begin
                    if (ov[i] != 0) begin
                        fcnt[i]++;
                        fmask[i][k] = 1'b1;
                    end
                end
                k++;
            end
            c++;
        end
        chk("frame_steps", k, WINDOW);
        cyc();
        cyc();
    endtask

    initial begin
        rst_n      = 1'b0;
        cfg_valid  = 1'b0;
        cfg_ch     = 2'd0;
        cfg_rate   = 4'd0;
        cfg_weight = 4'd0;
        start      = 1'b0;
        adv        = 1'b0;
        cyc();
        chk_en = 1;
        cyc();
        rst_n = 1'b1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_cfg_ready", int'(cfg_ready), 1);
        chk("rst_step_idx", int'(step_idx), 0);

        // Reset in the middle of a frame
        cfg(0, 8, 5);
        start = 1'b1; cyc(); start = 1'b0;
        adv = 1'b1;
        repeat (5) cyc();
        adv = 1'b0;
        rst_n = 1'b0; cyc(); rst_n = 1'b1;
        chk("midrst_out1", int'(out1), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_cfg_ready", int'(cfg_ready), 1);
        chk("midrst_step_idx", int'(step_idx), 0);
        run_frame(0, 0, 0);
        chk("midrst_fires", fcnt[0] + fcnt[1] + fcnt[2] + fcnt[3], 0);

        // Rate accuracy and frame end
        cfg(0, 0, 15); cfg(1, 1, 15); cfg(2, 8, 15); cfg(3, 15, 15);
        run_frame(0, 0, 0);
        chk("rate0_cnt", fcnt[0], 0);
        chk("rate1_cnt", fcnt[1], 1);
        chk("rate8_cnt", fcnt[2], 8);
        chk("rate15_cnt", fcnt[3], 15);
        chk("rate8_mask", int'(fmask[2]), 'hAAAA);
        chk("rate1_mask", int'(fmask[1]), 'h8000);
        chk("rate15_mask", int'(fmask[3]), 'hFFFE);
        chk("busy_cycles", busy_cnt, 16);
        chk("done_cycles", done_cnt, 1);
        chk("after_out3", int'(out3), 0);
        chk("after_out4", int'(out4), 0);

        // Hold with adv 1,0,0,1
        run_frame(1, 0, 0);
        chk("hold_rate8_mask", int'(fmask[2]), 'hAAAA);
        chk("hold_rate15_cnt", fcnt[3], 15);
        chk("hold_done_cycles", done_cnt, 1);

        // Config write during RUN is dropped
        cfg(3, 2, 7);
        run_frame(0, 0, 1);
        chk("runcfg_ch3_cnt", fcnt[3], 2);

        // Config together with start is honoured
        cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_rate = 4'd15; cfg_weight = 4'd9;
        run_frame(0, 0, 0);
        chk("startcfg_ch3_cnt", fcnt[3], 15);

        // start mid-RUN is ignored
        run_frame(0, 1, 0);
        chk("restart_rate8_cnt", fcnt[2], 8);
        chk("restart_busy_cycles", busy_cnt, 16);
        chk("restart_done_cycles", done_cnt, 1);

        // Randomized configurations and adv pacing
        for (int f = 0; f < 8; f++) begin
            for (int ch = 0; ch < 4; ch++) begin
                if ($urandom_range(0, 3) != 0)
                    cfg(ch, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
            end
            run_frame(2, ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1));
        end

        chk_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
